// File: rtl/fir_pkg.sv
// Shared definitions for the FIR multiply-accumulate sequencer: default
// widths, accumulator width derivation and the FSM state encoding.
package fir_pkg;

   localparam int DATA_W_DEFAULT = 16;
   localparam int TAPS_DEFAULT   = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // Full product width plus enough guard bits that summing TAPS
   // maximum products can never overflow.
   function automatic int acc_width(input int data_w, input int taps);
      return 2 * data_w + $clog2(taps);
   endfunction

endpackage

// File: rtl/fir_coef_regfile.sv
// Coefficient register file: one write port, every entry resets to 1,
// combinational read indexed by the current tap number.
module fir_coef_regfile
   import fir_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int TAPS   = TAPS_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [3:0]        addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [3:0]        rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] coef_mem [TAPS];

   // Coefficient storage; writes to addresses beyond the tap count fall through
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TAPS; i++) begin
            coef_mem[i] <= DATA_W'(1);
         end
      end else if (we) begin
         for (int i = 0; i < TAPS; i++) begin
            if (addr == 4'(i)) begin
               coef_mem[i] <= wdata;
            end
         end
      end
   end

   // Read by tap index; an out-of-range index reads as zero
   always_comb begin
      rd_data = '0;
      if ({1'b0, rd_addr} < 5'(TAPS)) begin
         rd_data = coef_mem[rd_addr];
      end
   end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR filter: one shared multiplier-accumulator walks all
// taps of a circular delay line, then holds the result on a valid/ready
// output. Optional output saturation is enabled by defining FIR_SAT_EN;
// without it the result wraps to the low DATA_W bits of the accumulator.
module fir_mac_sequencer
   import fir_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int TAPS   = TAPS_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              coef_we,
   input  logic [3:0]        coef_addr,
   input  logic [DATA_W-1:0] coef_wdata,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy
);

   localparam int ACC_W  = acc_width(DATA_W, TAPS);
   localparam int PROD_W = 2 * DATA_W;
   localparam int PTR_W  = 4;
   localparam int CNT_W  = 5;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(TAPS - 1);
   // The tap counter runs one past the last tap: products are registered,
   // so the final accumulate happens one cycle after the last multiply.
   localparam logic [CNT_W-1:0] TAP_END  = CNT_W'(TAPS);

   state_t              state_reg;
   logic [PTR_W-1:0]    wr_ptr_reg;
   logic [PTR_W-1:0]    rd_ptr_reg;
   logic [CNT_W-1:0]    tap_reg;
   logic [ACC_W-1:0]    acc_reg;
   logic [ACC_W-1:0]    acc_sum;
   logic [PROD_W-1:0]   prod_reg;
   logic [PROD_W-1:0]   prod_next;
   logic [DATA_W-1:0]   sample_mem [TAPS];
   logic [DATA_W-1:0]   sample_rd;
   logic [DATA_W-1:0]   coef_rd;
   logic [DATA_W-1:0]   result;
   logic                in_ready_reg;
   logic                out_valid_reg;
   logic                busy_reg;
   logic [DATA_W-1:0]   out_data_reg;
   logic                accept;
   logic                coef_wr_en;

   assign accept     = in_valid & in_ready_reg;
   // Coefficients only change while no computation is in flight
   assign coef_wr_en = coef_we & (state_reg == ST_IDLE);
   assign sample_rd  = sample_mem[rd_ptr_reg];
   assign prod_next  = PROD_W'(coef_rd) * PROD_W'(sample_rd);
   assign acc_sum    = acc_reg + ACC_W'(prod_reg);

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign busy      = busy_reg;

   fir_coef_regfile #(
      .DATA_W (DATA_W),
      .TAPS   (TAPS)
   ) u_coef (
      .clk     (clk),
      .reset   (reset),
      .we      (coef_wr_en),
      .addr    (coef_addr),
      .wdata   (coef_wdata),
      .rd_addr (tap_reg[PTR_W-1:0]),
      .rd_data (coef_rd)
   );

`ifdef FIR_SAT_EN
   // Clamp to all-ones when any accumulator bit above the output width is set
   assign result = (|acc_sum[ACC_W-1:DATA_W]) ? '1 : acc_sum[DATA_W-1:0];
`else
   assign result = acc_sum[DATA_W-1:0];
`endif

   // Delay line: each accepted sample overwrites the oldest slot
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < TAPS; i++) begin
            sample_mem[i] <= '0;
         end
      end else if (accept) begin
         sample_mem[wr_ptr_reg] <= in_data;
      end
   end

   // Sequencer FSM with datapath registers and registered handshake outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_IDLE;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         tap_reg       <= '0;
         acc_reg       <= '0;
         prod_reg      <= '0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         busy_reg      <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  // Newest sample sits at the old write pointer; walk backwards from it
                  rd_ptr_reg   <= wr_ptr_reg;
                  wr_ptr_reg   <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + 1'b1;
                  acc_reg      <= '0;
                  prod_reg     <= '0;
                  tap_reg      <= '0;
                  in_ready_reg <= 1'b0;
                  busy_reg     <= 1'b1;
                  state_reg    <= ST_MAC;
               end
            end
            ST_MAC: begin
               if (tap_reg != TAP_END) begin
                  prod_reg   <= prod_next;
                  rd_ptr_reg <= (rd_ptr_reg == '0) ? LAST_PTR : rd_ptr_reg - 1'b1;
               end
               acc_reg <= acc_sum;
               tap_reg <= tap_reg + 1'b1;
               if (tap_reg == TAP_END) begin
                  out_data_reg  <= result;
                  out_valid_reg <= 1'b1;
                  state_reg     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  busy_reg      <= 1'b0;
                  state_reg     <= ST_IDLE;
               end
            end
            default: begin
               state_reg     <= ST_IDLE;
               in_ready_reg  <= 1'b1;
               out_valid_reg <= 1'b0;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard testbench for fir_mac_sequencer: directed samples push their
// expected result; a monitor pops and compares on every output transfer.
// Define FIR_SAT_EN for both bench and RTL to check the saturating build.
module tb_fir_mac_sequencer;

   localparam int DATA_W = 16;
   localparam int TAPS   = 10;

   logic              clk;
   logic              reset;
   logic              coef_we;
   logic [3:0]        coef_addr;
   logic [DATA_W-1:0] coef_wdata;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              busy;

   int                n_checks = 0;
   int                n_errors = 0;
   int                n_out    = 0;
   logic [15:0]       exp_q [$];
   logic [15:0]       mon_exp;

   fir_mac_sequencer #(
      .DATA_W (DATA_W),
      .TAPS   (TAPS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_wdata (coef_wdata),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // Monitor: compare every completed output transfer against the scoreboard
   always begin
      @(negedge clk);
      #1;
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: got 0x%0h, required no output", out_data);
         end else begin
            mon_exp = exp_q.pop_front();
            check($sformatf("out%0d", n_out), 32'(out_data), 32'(mon_exp));
         end
         n_out++;
      end
   end

   // All tasks are entered on a falling edge and return on a falling edge
   task automatic send(input logic [15:0] d, input logic [15:0] e, input bit push);
      int t;
      t = 0;
      while (!in_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_timeout: in_ready=0 after %0d cycles, required 1", t);
         return;
      end
      if (push) exp_q.push_back(e);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic write_coef(input logic [3:0] a, input logic [15:0] d);
      coef_we    = 1'b1;
      coef_addr  = a;
      coef_wdata = d;
      @(negedge clk);
      coef_we    = 1'b0;
   endtask

   task automatic drain(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 200) begin
         @(negedge clk);
         t++;
      end
      check(name, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      in_valid = 1'b0;
      coef_we  = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int lat;
      int seen;
      logic [15:0] e;

      reset = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      @(negedge clk);
      do_reset();

      // Post-reset outputs
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_busy",      32'(busy),      32'd0);

      // Default coefficients, samples 1..10 back-to-back: running sums
      for (int i = 1; i <= 10; i++) begin
         send(16'(i), 16'(i * (i + 1) / 2), 1'b1);
      end
      drain("drain_ramp");

      // coef[0]=2 written on the accept edge, other taps zero; latency 11
      for (int i = 1; i < 10; i++) write_coef(4'(i), 16'h0000);
      coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 16'h0002;
      send(16'h1234, 16'h2468, 1'b1);
      coef_we = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 32'(lat), 32'd11);
      drain("drain_latency");

      // Backpressure: out_ready low for 5 cycles of HOLD
      out_ready = 1'b0;
      send(16'h0005, 16'h000A, 1'b1);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      for (int c = 0; c < 5; c++) begin
         check($sformatf("stall%0d", c), 32'({out_valid, in_ready, busy, out_data}),
               32'({1'b1, 1'b0, 1'b1, 16'h000A}));
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("post_transfer", 32'({out_valid, in_ready, busy}), 32'({1'b0, 1'b1, 1'b0}));
      drain("drain_stall");

      // Maximum values: wraps to the sample count, or clamps when saturating
      do_reset();
      for (int i = 0; i < 10; i++) write_coef(4'(i), 16'hFFFF);
      for (int i = 1; i <= 10; i++) begin
`ifdef FIR_SAT_EN
         e = 16'hFFFF;
`else
         e = 16'(i);
`endif
         send(16'hFFFF, e, 1'b1);
      end
      drain("drain_max");

      // Ignored coefficient writes: during MAC, and to an out-of-range address
      do_reset();
      send(16'd3, 16'd3, 1'b1);
      coef_we = 1'b1; coef_addr = 4'd3; coef_wdata = 16'h0050;
      repeat (3) @(negedge clk);
      coef_we = 1'b0;
      drain("drain_we_mac");
      write_coef(4'd12, 16'h0007);
      send(16'd4, 16'd7,  1'b1);
      send(16'd5, 16'd12, 1'b1);
      send(16'd6, 16'd18, 1'b1);
      drain("drain_we_ignored");

      // Reset at tap 4 aborts the computation
      do_reset();
      send(16'd9, 16'd0, 1'b0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (out_valid) seen++;
         @(negedge clk);
      end
      check("abort_no_valid", 32'(seen), 32'd0);
      send(16'd7, 16'd7, 1'b1);
      drain("drain_abort");

      check("output_count", 32'(n_out), 32'd27);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fir_mac_sequencer.md
FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample/coefficient/output width.
REQ-002 SHALL have parameter TAPS, default 10, number of filter taps, legal range 2..16.
REQ-003 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have ports coef_we in 1, coef_addr in 4, coef_wdata in DATA_W: coefficient write port.
REQ-006 SHALL have ports in_valid in 1, in_ready out 1, in_data in DATA_W: sample input handshake.
REQ-007 SHALL have ports out_valid out 1, out_ready in 1, out_data out DATA_W: result output handshake.
REQ-008 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-009 SHALL implement FSM IDLE -> MAC -> HOLD -> IDLE with a single shared multiplier-accumulator.
REQ-010 SHALL keep the delay line as a TAPS-entry circular buffer with a write pointer wrapping TAPS-1 -> 0.
REQ-011 IDLE: in_ready=1; on in_valid&in_ready, write in_data at wr_ptr, advance wr_ptr, clear acc, tap counter=0, go MAC.
REQ-012 MAC: in_ready=0; tap counter k=0..TAPS-1 adds coef[k]*sample[newest-k mod TAPS], one tap per cycle.
REQ-013 After the tap TAPS-1 accumulate, SHALL enter HOLD with out_valid=1; accept-to-out_valid latency = TAPS+1 cycles (11 at default).
REQ-014 HOLD: out_data stable and out_valid held until out_ready=1; transfer returns FSM to IDLE next cycle.
REQ-015 Throughput: at most one sample per TAPS+2 cycles with out_ready tied high.
REQ-016 Arithmetic unsigned; accumulator width 2*DATA_W+ceil(log2(TAPS)); no accumulator overflow.
REQ-017 out_data SHALL be acc[DATA_W-1:0] (wrap) unless FIR_SAT_EN is defined.
REQ-018 coef_we honoured only in IDLE and only for coef_addr < TAPS; otherwise silently ignored.
REQ-019 Simultaneous coef_we and sample accept in IDLE: coefficient written on that edge and used by that sample's computation.

Reset
REQ-020 On reset: FSM=IDLE, wr_ptr=0, delay line all 0, acc=0, all coefficients=1.
REQ-021 Reset outputs: in_ready=1 from first post-reset cycle, out_valid=0, out_data=0, busy=0.
REQ-022 Reset mid-MAC or mid-HOLD SHALL abort the computation; no result emitted.

Configuration
REQ-023 Macro FIR_SAT_EN defined: out_data = all-ones when acc exceeds 2^DATA_W-1, else acc low bits.
REQ-024 Macro FIR_SAT_EN undefined: out_data = acc low DATA_W bits, no saturation logic instantiated.

Structure
REQ-025 Shared package fir_pkg SHALL hold DATA_W/TAPS defaults, ACC_W derivation and the FSM state typedef.
REQ-026 Coefficient storage SHALL be sub-module fir_coef_regfile (write port, reset-to-1, async read by tap index).

Verification
REQ-027 Reset, default coefs, samples 1..10 back-to-back, out_ready=1 -> outputs 1,3,6,10,15,21,28,36,45,55.
REQ-028 coef[0]=2, coef[1..9]=0, sample 0x1234 -> out_data 0x2468 exactly 11 cycles after accept.
REQ-029 out_ready low 5 cycles in HOLD -> out_data stable, in_ready=0, busy=1 throughout; transfer on 6th cycle.
REQ-030 All coefs 0xFFFF, ten samples 0xFFFF -> 10th out_data 0x000A without FIR_SAT_EN, 0xFFFF with it.
REQ-031 coef_we to addr 3 during MAC and to addr 12 in IDLE -> coefficients unchanged, results unaffected.
REQ-032 Reset asserted at MAC tap 4 -> out_valid never asserts, next sample 7 with default coefs yields 7.
